// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg : shared types and sizes for the rr_arb8 round-robin arbiter
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb8_dec.sv
// ---------------------------------------------------------------------------
// dec3to8_en : 3-to-8 one-hot decoder with enable, all zero when disabled
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dec3to8_en
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_onehot
);

    for (genvar i = 0; i < N_REQ; i++) begin : g_dec
        assign o_onehot[i] = i_en && (i_idx == IDX_W'(i));
    end

endmodule

`default_nettype wire

// File: rtl/rr_arb8.sv
// ---------------------------------------------------------------------------
// rr_arb8  : 8-client round-robin arbiter with hold limit and break-before-make gap
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] c_hold_last = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               timeout_q, timeout_d;
    logic               w_limit;
    logic               w_drop;

    // Rotate so that ptr+1 sits at bit 0, take the lowest set bit, rotate back.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   off;
        dbl = {r, r} >> ({1'b0, p} + 4'd1);
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        return p + IDX_W'(1) + off;
    endfunction

    assign w_limit = (MAX_HOLD != 0) && (hold_q == c_hold_last);
    assign w_drop  = !req[idx_q];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = rr_pick(req, ptr_q);
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rel || w_drop || w_limit) begin
                    state_d   = GAP;
                    valid_d   = 1'b0;
                    ptr_d     = idx_q;
                    hold_d    = '0;
                    // Only a release caused solely by the hold limit counts as forced.
                    timeout_d = w_limit && !rel && !w_drop;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(N_REQ - 1);
            idx_q     <= '0;
            valid_q   <= 1'b0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    dec3to8_en u_dec (
        .i_idx    (idx_q),
        .i_en     (valid_q),
        .o_onehot (gnt)
    );

    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

`default_nettype wire
